pdm_mic_ctrl: RTL
=================

Name: pdm_mic_ctrl

Overview:
Sequencing controller for one PDM microphone channel and its CIC3 decimator/HPF datapath. It runs in the same clock domain as the decimator (one clk per PDM bit). It performs the following:
- gates the microphone clock and holds the decimator in reset through mic wake-up;
- discards the initial filter-settling samples;
- applies HPF coefficient changes only on sample boundaries;
- buffers decimated PCM into a small FIFO with a valid/ready output and a sticky overflow flag.

Parameters:
WAKE_CYCLES, 16384, clk cycles with mic clock running and decimator held in reset before release (mic power-up time); must be >= 1
SETTLE_SAMPLES, 4, decimator pcm_valid pulses discarded after release; 0 = none discarded
FIFO_DEPTH, 4, output FIFO entries; power of 2, >= 2

Ports:
clk  in  1  PDM-rate clock, shared with the decimator
rst_n  in  1  synchronous reset, active-low
enable  in  1  level; 1 = capture requested
cfg_hpf_alpha  in  8  requested HPF coefficient (255 = bypass)
mic_clk_en  out  1  enables the clock driven to the microphone
cic_rst  out  1  active-high synchronous reset to the decimator
cic_hpf_alpha  out  8  coefficient presented to the decimator
cic_pcm  in  16  signed decimated sample from the decimator
cic_pcm_valid  in  1  one-cycle strobe, cic_pcm valid
m_data  out  16  signed PCM output (FIFO head)
m_valid  out  1  FIFO non-empty
m_ready  in  1  consumer accepts m_data when m_valid && m_ready
overflow  out  1  sticky; a sample was dropped because the FIFO was full
state  out  2  0=OFF 1=WAKE 2=SETTLE 3=RUN

Behaviour:
- Reset (rst_n==0 at a clk edge):
  - state=OFF, mic_clk_en=0, cic_rst=1, cic_hpf_alpha=255.
  - FIFO empty, m_valid=0, m_data=0, overflow=0.
  - Wake counter and settle counter cleared.
  - Reset asserted mid-operation has the same effect; no FIFO entry survives.
- OFF:
  - mic_clk_en=0, cic_rst=1.
  - cic_hpf_alpha tracks cfg_hpf_alpha every cycle.
  - enable==1 -> WAKE next cycle. Wake counter loads 0 and overflow clears on this transition.
- WAKE:
  - mic_clk_en=1, cic_rst=1; the counter increments each cycle.
  - After exactly WAKE_CYCLES cycles in WAKE -> SETTLE. cic_rst is first 0 in the first SETTLE cycle.
- SETTLE:
  - mic_clk_en=1, cic_rst=0.
  - Each cic_pcm_valid increments the settle count and the sample is dropped (not pushed).
  - When the SETTLE_SAMPLES-th pulse is dropped -> RUN next cycle.
  - SETTLE_SAMPLES==0: SETTLE lasts exactly one cycle. Any cic_pcm_valid arriving in that cycle is still dropped.
- RUN:
  - Each cic_pcm_valid pushes cic_pcm into the FIFO.
  - Latency: a push at edge t (FIFO empty) gives m_valid=1 and m_data=sample after edge t.
  - FIFO full and no pop in that cycle: the sample is dropped and overflow=1 (stays set until the next OFF->WAKE transition or reset).
  - Full with simultaneous push and pop: pop head, accept push, count unchanged, no overflow.
  - Output order is strict FIFO.
  - m_data holds stable while m_valid && !m_ready.
- HPF coefficient, outside OFF:
  - cic_hpf_alpha updates to cfg_hpf_alpha only in a cycle where cic_pcm_valid==1.
  - It is visible to the decimator from the next cycle, so it never changes mid-filter-update.
  - A coefficient change does not restart SETTLE.
- enable deasserted in WAKE, SETTLE or RUN:
  - OFF next cycle: mic_clk_en=0, cic_rst=1, FIFO flushed (m_valid=0).
  - Counters cleared. overflow retains its value.
  - A cic_pcm_valid in the same cycle as the enable==0 sample is dropped.
- enable re-asserted while in OFF restarts the full WAKE sequence; there is no shortcut.
- Widths:
  - Wake counter is clog2(WAKE_CYCLES+1) bits; settle counter is clog2(SETTLE_SAMPLES+1) bits, minimum 1.
  - FIFO count is clog2(FIFO_DEPTH)+1 bits; pointers wrap modulo FIFO_DEPTH.
- m_valid, overflow and state are registered outputs. mic_clk_en and cic_rst are registered and decode state.

Test Plan:
- Parameters WAKE_CYCLES=8, SETTLE_SAMPLES=2, FIFO_DEPTH=4 unless noted.
- Scenario 1: rst_n=0 for 3 cycles, enable=1 -> state=0, mic_clk_en=0, cic_rst=1, cic_hpf_alpha=255, m_valid=0, overflow=0 throughout reset. The state is already 1 at the edge that follows the first edge with rst_n=1.
- Scenario 2: enable=1 from OFF -> mic_clk_en=1 after 1 edge; cic_rst=1 for exactly 8 WAKE cycles then 0; pcm pulses 0x0100 and 0x0200 are dropped; state=3 after the second pulse.
- Scenario 3: in RUN, pulses 0x1111, 0x2222, 0x3333 with m_ready=1 -> m_valid one cycle after each pulse, values in order, no overflow.
- Scenario 4: in RUN with m_ready=0, 5 pulses 1..5 -> FIFO holds 1..4, overflow=1 after pulse 5. With m_ready=1 the output is 1,2,3,4, then m_valid=0. A 6th pulse coinciding with a pop while full is accepted.
- Scenario 5: cfg_hpf_alpha changes 255->200 between pulses in RUN -> cic_hpf_alpha remains 255 until the cycle after the next cic_pcm_valid, then 200.
- Scenario 6: enable=0 with 2 entries buffered in RUN -> next cycle state=0, m_valid=0, cic_rst=1, mic_clk_en=0. Re-enable -> overflow clears and the full 8-cycle wake repeats. rst_n=0 in WAKE -> OFF immediately.

Source files
------------

// File: rtl/pdm_mic_ctrl.sv
// pdm_mic_ctrl: sequencing controller for one PDM microphone channel.
// Gates the mic clock, holds the CIC decimator in reset through mic wake-up,
// discards filter-settling samples, retimes HPF coefficient changes onto
// sample boundaries, and buffers PCM in a small FIFO with a sticky overflow.
//
// Output handshake: m_data is a beat when m_valid && m_ready at a clk edge.
// m_valid never drops and m_data never changes while m_valid && !m_ready,
// except when enable falls or reset is asserted, which flush the FIFO.
module pdm_mic_ctrl #(
  parameter int WAKE_CYCLES    = 16384,
  parameter int SETTLE_SAMPLES = 4,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  cfg_hpf_alpha,
  output logic        mic_clk_en,
  output logic        cic_rst,
  output logic [7:0]  cic_hpf_alpha,
  input  logic [15:0] cic_pcm,
  input  logic        cic_pcm_valid,
  output logic [15:0] m_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic        overflow,
  output logic [1:0]  state
);

  localparam int WW = $clog2(WAKE_CYCLES + 1);
  localparam int SW = (SETTLE_SAMPLES == 0) ? 1 : $clog2(SETTLE_SAMPLES + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);
  localparam logic [SW-1:0] SET_LAST  = SW'((SETTLE_SAMPLES == 0) ? 0 : SETTLE_SAMPLES - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WAKE   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_RUN    = 2'd3
  } state_t;

  state_t          st_q, st_d;
  logic [WW-1:0]   wake_q, wake_d;
  logic [SW-1:0]   settle_q, settle_d;
  logic [15:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_q, wr_q;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            push, pop, full, accept, drop, flush;

  assign state  = st_q;
  assign m_data = m_valid ? mem[rd_q] : 16'h0000;

  // Next-state and counter logic; enable low always returns to OFF.
  always_comb begin
    st_d     = st_q;
    wake_d   = '0;
    settle_d = settle_q;
    case (st_q)
      ST_OFF: begin
        settle_d = '0;
        if (enable) st_d = ST_WAKE;
      end
      ST_WAKE: begin
        wake_d = wake_q + WW'(1);
        if (!enable) begin
          st_d   = ST_OFF;
          wake_d = '0;
        end else if (wake_q == WAKE_LAST) begin
          st_d   = ST_SETTLE;
          wake_d = '0;
        end
      end
      ST_SETTLE: begin
        if (!enable) begin
          st_d     = ST_OFF;
          settle_d = '0;
        end else if (SETTLE_SAMPLES == 0) begin
          st_d = ST_RUN;
        end else if (cic_pcm_valid) begin
          settle_d = settle_q + SW'(1);
          if (settle_q == SET_LAST) st_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (!enable) begin
          st_d     = ST_OFF;
          settle_d = '0;
        end
      end
      default: st_d = ST_OFF;
    endcase
  end

  // FIFO control: a push while full succeeds only if the head pops the same cycle.
  always_comb begin
    push   = (st_q == ST_RUN) && enable && cic_pcm_valid;
    pop    = m_valid && m_ready;
    full   = (cnt_q == DEPTH);
    accept = push && (!full || pop);
    drop   = push && full && !pop;
    flush  = (st_d == ST_OFF);
    cnt_d  = cnt_q;
    if (accept && !pop)      cnt_d = cnt_q + CW'(1);
    else if (!accept && pop) cnt_d = cnt_q - CW'(1);
  end

  // Control registers, counters, coefficient retiming and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q          <= ST_OFF;
      wake_q        <= '0;
      settle_q      <= '0;
      mic_clk_en    <= 1'b0;
      cic_rst       <= 1'b1;
      cic_hpf_alpha <= 8'd255;
      overflow      <= 1'b0;
      rd_q          <= '0;
      wr_q          <= '0;
      cnt_q         <= '0;
      m_valid       <= 1'b0;
    end else begin
      st_q       <= st_d;
      wake_q     <= wake_d;
      settle_q   <= settle_d;
      mic_clk_en <= (st_d != ST_OFF);
      cic_rst    <= !((st_d == ST_SETTLE) || (st_d == ST_RUN));
      if ((st_q == ST_OFF) || cic_pcm_valid) cic_hpf_alpha <= cfg_hpf_alpha;
      if ((st_q == ST_OFF) && enable) overflow <= 1'b0;
      else if (drop)                  overflow <= 1'b1;
      if (flush) begin
        rd_q    <= '0;
        wr_q    <= '0;
        cnt_q   <= '0;
        m_valid <= 1'b0;
      end else begin
        if (accept) wr_q <= wr_q + AW'(1);
        if (pop)    rd_q <= rd_q + AW'(1);
        cnt_q   <= cnt_d;
        m_valid <= (cnt_d != '0);
      end
    end
  end

  // FIFO storage; contents are don't-care while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_q] <= cic_pcm;
  end

endmodule
